vga_draw_scheduler: RTL

- Sequences all VGA framebuffer writes for the game screen.
- After reset it paints the full background once.
- On each frame tick it erases the old Pac-Man sprite box by restoring the background there, then draws the sprite at its new position.
- It drives the draw-source mux select, the shared pixel coordinates, the sprite-ROM offsets and the plot strobe to the VGA adapter.

---
 rtl/vga_draw_scheduler_if.sv | 27 ++
 rtl/vga_draw_scheduler.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/vga_draw_scheduler_if.sv
// Draw-scheduler bus: frame tick and sprite request in, pixel strobe out.
// master = scheduler side, slave = game logic / VGA adapter side.
interface vga_draw_scheduler_if;
  logic       frame_tick;
  logic [7:0] pac_x;
  logic [6:0] pac_y;
  logic [7:0] draw_x;
  logic [6:0] draw_y;
  logic [2:0] sprite_dx;
  logic [2:0] sprite_dy;
  logic [2:0] mux_select;
  logic       plot;
  logic       busy;
  logic       frame_done;

  modport master (
    input  frame_tick, pac_x, pac_y,
    output draw_x, draw_y, sprite_dx, sprite_dy,
    output mux_select, plot, busy, frame_done
  );

  modport slave (
    output frame_tick, pac_x, pac_y,
    input  draw_x, draw_y, sprite_dx, sprite_dy,
    input  mux_select, plot, busy, frame_done
  );
endinterface

// File: rtl/vga_draw_scheduler.sv
// Sequences framebuffer writes: full background, then erase/draw per frame.
// Ports: clock, resetn (async low), bus (frame_tick/pac_x/pac_y in, pixels out).
module vga_draw_scheduler #(
  parameter int         SCREEN_W = 160,
  parameter int         SCREEN_H = 120,
  parameter int         SPRITE   = 5,
  parameter logic [7:0] START_X  = 8'd76,
  parameter logic [6:0] START_Y  = 7'd56
) (
  input logic                  clock,
  input logic                  resetn,
  vga_draw_scheduler_if.master bus
);

  typedef enum logic [1:0] {
    S_FULL_BG, S_WAIT, S_ERASE, S_DRAW
  } state_t;

  localparam logic [7:0] XMAX = 8'(SCREEN_W - 1);
  localparam logic [6:0] YMAX = 7'(SCREEN_H - 1);
  localparam logic [7:0] XLIM = 8'(SCREEN_W - SPRITE);
  localparam logic [6:0] YLIM = 7'(SCREEN_H - SPRITE);
  localparam logic [2:0] SMAX = 3'(SPRITE - 1);

  state_t     r_state, w_next;
  logic [7:0] r_cx, r_old_x, r_new_x;
  logic [6:0] r_cy, r_old_y, r_new_y;
  logic [2:0] r_dx, r_dy;
  logic       r_done;

  logic [7:0] w_clamp_x;
  logic [6:0] w_clamp_y;
  logic       w_moved, w_bg_last, w_spr_last;

  assign w_clamp_x  = (bus.pac_x > XLIM) ? XLIM : bus.pac_x;
  assign w_clamp_y  = (bus.pac_y > YLIM) ? YLIM : bus.pac_y;
  assign w_moved    = (w_clamp_x != r_old_x) || (w_clamp_y != r_old_y);
  assign w_bg_last  = (r_cx == XMAX) && (r_cy == YMAX);
  assign w_spr_last = (r_dx == SMAX) && (r_dy == SMAX);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) r_state <= S_FULL_BG;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_FULL_BG: if (w_bg_last) w_next = S_WAIT;
      S_WAIT: begin
        if (bus.frame_tick)
          w_next = w_moved ? S_ERASE : S_DRAW;
      end
      S_ERASE: if (w_spr_last) w_next = S_DRAW;
      S_DRAW:  if (w_spr_last) w_next = S_WAIT;
      default: w_next = S_FULL_BG;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_cx    <= '0;
      r_cy    <= '0;
      r_dx    <= '0;
      r_dy    <= '0;
      r_old_x <= START_X;
      r_old_y <= START_Y;
      r_new_x <= START_X;
      r_new_y <= START_Y;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_FULL_BG: begin
          if (r_cx == XMAX) begin
            r_cx <= '0;
            r_cy <= (r_cy == YMAX) ? '0 : r_cy + 7'd1;
          end else begin
            r_cx <= r_cx + 8'd1;
          end
        end
        S_WAIT: begin
          r_dx <= '0;
          r_dy <= '0;
          if (bus.frame_tick) begin
            r_new_x <= w_clamp_x;
            r_new_y <= w_clamp_y;
          end
        end
        S_ERASE, S_DRAW: begin
          if (r_dx == SMAX) begin
            r_dx <= '0;
            r_dy <= (r_dy == SMAX) ? '0 : r_dy + 3'd1;
          end else begin
            r_dx <= r_dx + 3'd1;
          end
          if (r_state == S_DRAW && w_spr_last) begin
            r_old_x <= r_new_x;
            r_old_y <= r_new_y;
            r_done  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.plot       = 1'b0;
    bus.mux_select = 3'b000;
    bus.draw_x     = '0;
    bus.draw_y     = '0;
    bus.sprite_dx  = '0;
    bus.sprite_dy  = '0;
    bus.busy       = (r_state != S_WAIT);
    bus.frame_done = r_done;
    unique case (r_state)
      S_FULL_BG: begin
        bus.plot   = 1'b1;
        bus.draw_x = r_cx;
        bus.draw_y = r_cy;
      end
      S_ERASE: begin
        bus.plot      = 1'b1;
        bus.draw_x    = r_old_x + {5'b0, r_dx};
        bus.draw_y    = r_old_y + {4'b0, r_dy};
        bus.sprite_dx = r_dx;
        bus.sprite_dy = r_dy;
      end
      S_DRAW: begin
        bus.plot       = 1'b1;
        bus.mux_select = 3'b001;
        bus.draw_x     = r_new_x + {5'b0, r_dx};
        bus.draw_y     = r_new_y + {4'b0, r_dy};
        bus.sprite_dx  = r_dx;
        bus.sprite_dy  = r_dy;
      end
      default: ;
    endcase
    // async reset must silence the write strobe immediately
    if (!resetn) bus.plot = 1'b0;
  end

endmodule
